fibo_engine: RTL and testbench
==============================

// Module: fibo_engine
// PURPOSE
//  Parametrised sequential Fibonacci engine that succeeds the fixed 32-bit fibo_fun core.
//  Computes F(n), with F(0)=0 and F(1)=1, either wrapping modulo 2^DATA_W or reduced modulo a run-time modulus.
//  Reports overflow on the wrapping path.
//  Keeps the ap_ctrl_hs start/done/idle/ready handshake so it drops into existing wrappers; optional key lock.
// PARAMETERS
//  DATA_W   32  width of result, modulus and internal a/b registers
//  N_W      32  width of index n and iteration counter
//  KEY_W    64  working_key width (used only with FIBO_KEY_LOCK_EN)
//  KEY_VAL  64'h0  correct unlock key (used only with FIBO_KEY_LOCK_EN)
// PORTS
//  ap_clk       in   1       clock, rising edge
//  ap_rst_n     in   1       asynchronous active-low reset
//  ap_start     in   1       request; sampled only in IDLE
//  ap_done      out  1       one-cycle pulse: ap_return/ap_ovf valid
//  ap_idle      out  1       high while in IDLE
//  ap_ready     out  1       one-cycle pulse, coincident with ap_done
//  n            in   N_W     index, latched on start acceptance
//  mod_m        in   DATA_W  modulus, latched with n; 0 = wrap mod 2^DATA_W
//  ap_return    out  DATA_W  F(n) (reduced), held until next ap_done
//  ap_ovf       out  1       F(n) exceeded 2^DATA_W-1 (mod_m==0 only), held with ap_return
//  working_key  in   KEY_W   only present with FIBO_KEY_LOCK_EN
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE; ap_return=0, ap_ovf=0, ap_done=0, ap_ready=0, ap_idle=1.
//   - Reset mid-run aborts immediately; no done pulse.
//  FSM states:
//   - IDLE: ap_start=1 -> latch n into cnt and mod_m into m; load a=0, b=(m==1)?0:1; clear ovf_a/ovf_b; go to CALC.
//   - CALC: cnt==0 -> register result=a, ovf=ovf_a; go to DONE.
//     Otherwise a<=b; b<=madd(a,b); ovf_a<=ovf_b; ovf_b<=ovf_a|ovf_b|carry; cnt<=cnt-1.
//   - DONE: ap_done=ap_ready=1 for this cycle only; go to IDLE.
//  madd: (DATA_W+1)-bit sum s=a+b.
//   - m==0: result s[DATA_W-1:0], carry=s[DATA_W].
//   - m!=0: result s>=m ? s-m : s, carry=0. a,b<m holds by construction.
//  Latency: ap_done rises n+2 cycles after the edge that accepts ap_start, i.e. n+1 CALC cycles plus DONE.
//  Throughput: one job per n+3 cycles; ap_start held high in IDLE/DONE starts the next job on the IDLE cycle.
//  ap_start outside IDLE is ignored. n and mod_m changes after acceptance have no effect.
//  ap_return and ap_ovf update only on entry to DONE and are stable otherwise.
//  n=0 -> F=0 after 2 cycles. mod_m=1 -> result always 0.
//  Registered outputs only; no combinational path from inputs to outputs.
// CONFIGURATION
//  FIBO_KEY_LOCK_EN defined:
//   - working_key port exists; key_ok=(working_key==KEY_VAL) is registered at start acceptance.
//   - key_ok=0 -> ap_return is the bitwise inverse of the true result and ap_ovf is forced to 0.
//   - Timing is unchanged either way.
//  FIBO_KEY_LOCK_EN undefined: no working_key port; results are always true.
// STRUCTURE
//  Package fibo_pkg:
//   - fibo_state_t enum {IDLE, CALC, DONE}.
//   - Default widths DATA_W/N_W/KEY_W as localparams.
//  Sub-module fibo_mod_add:
//   - Combinational; inputs a, b, m; outputs sum, carry.
//   - Instantiated once for the b update.
//  Top holds the FSM, counter, a/b/ovf registers, output registers and the optional key compare.
// TESTING
//  1. n=10, mod_m=0, DATA_W=32 -> ap_return=55, ap_ovf=0; ap_done exactly 12 cycles after accept.
//  2. n=0 and n=1 back to back with ap_start held high -> ap_return 0 then 1; ap_idle pulses high one cycle between jobs.
//  3. DATA_W=16: n=24 -> 46368, ovf=0; n=25 -> 75025 mod 65536=9489, ovf=1.
//  4. n=20, mod_m=1000 -> 765 (6765 mod 1000); mod_m=1, n=5 -> 0.
//  5. ap_rst_n low in the 5th CALC cycle of n=30 -> outputs 0, ap_idle=1 at once; a fresh n=7 run then returns 13.
//  6. FIBO_KEY_LOCK_EN, n=10: correct key -> 55; wrong key -> 32'hFFFFFFC8; ap_start during CALC ignored.

Source files
------------

// File: rtl/fibo_pkg.sv
// fibo_pkg: shared types and default widths for the Fibonacci engine.
// Holds the FSM state enum and the default DATA_W / N_W / KEY_W values.
package fibo_pkg;

    localparam int FIBO_DATA_W = 32;
    localparam int FIBO_N_W    = 32;
    localparam int FIBO_KEY_W  = 64;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } fibo_state_t;

endpackage

// File: rtl/fibo_mod_add.sv
// fibo_mod_add: combinational modular adder used for the b update.
// Ports: a, b, m in (DATA_W); sum out (DATA_W), carry out (wrap mode only).
module fibo_mod_add
    import fibo_pkg::*;
#(
    parameter int DATA_W = FIBO_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] m,
    output logic [DATA_W-1:0] sum,
    output logic              carry
);

    logic [DATA_W:0] s;
    logic [DATA_W:0] d;

    // One-bit-wider sum so a+b never loses its top bit before the
    // compare; a,b < m means a single conditional subtract suffices.
    always_comb begin
        s     = {1'b0, a} + {1'b0, b};
        d     = s - {1'b0, m};
        sum   = s[DATA_W-1:0];
        carry = 1'b0;
        if (m == '0) begin
            carry = s[DATA_W];
        end else if (s >= {1'b0, m}) begin
            sum = d[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/fibo_engine.sv
// fibo_engine: sequential F(n), wrapping mod 2^DATA_W (mod_m=0) or mod mod_m,
// with ap_ctrl_hs handshake (ap_start/ap_done/ap_idle/ap_ready).
// Ports: ap_clk, ap_rst_n, ap_start, n, mod_m in; ap_return, ap_ovf,
// ap_done, ap_idle, ap_ready out; working_key in only with FIBO_KEY_LOCK_EN.
module fibo_engine
    import fibo_pkg::*;
#(
    parameter int              DATA_W  = FIBO_DATA_W,
    parameter int              N_W     = FIBO_N_W,
    parameter int              KEY_W   = FIBO_KEY_W,
    parameter logic [KEY_W-1:0] KEY_VAL = '0
) (
`ifdef FIBO_KEY_LOCK_EN
    input  logic [KEY_W-1:0]  working_key,
`endif
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [N_W-1:0]    n,
    input  logic [DATA_W-1:0] mod_m,
    output logic [DATA_W-1:0] ap_return,
    output logic              ap_ovf
);

    fibo_state_t       state;
    fibo_state_t       state_n;
    logic              accept;
    logic              finish;
    logic [N_W-1:0]    cnt;
    logic [DATA_W-1:0] m_q;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              ovf_a;
    logic              ovf_b;
    logic [DATA_W-1:0] sum;
    logic              carry;
    logic              key_hit;
    logic              key_ok;

`ifdef FIBO_KEY_LOCK_EN
    assign key_hit = (working_key == KEY_VAL);
`else
    // Without the lock the engine acts as if the right key is always shown.
    logic [KEY_W-1:0] key_in;
    assign key_in  = KEY_VAL;
    assign key_hit = (key_in == KEY_VAL);
`endif

    fibo_mod_add #(
        .DATA_W(DATA_W)
    ) u_add (
        .a    (a),
        .b    (b),
        .m    (m_q),
        .sum  (sum),
        .carry(carry)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        finish  = 1'b0;
        unique case (state)
            IDLE: begin
                if (ap_start) begin
                    accept  = 1'b1;
                    state_n = CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    finish  = 1'b1;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ovf_a/ovf_b track whether the true F(k)/F(k+1) left the range.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt    <= '0;
            m_q    <= '0;
            a      <= '0;
            b      <= '0;
            ovf_a  <= 1'b0;
            ovf_b  <= 1'b0;
            key_ok <= 1'b0;
        end else if (accept) begin
            cnt    <= n;
            m_q    <= mod_m;
            a      <= '0;
            b      <= {{(DATA_W-1){1'b0}}, (mod_m != DATA_W'(1))};
            ovf_a  <= 1'b0;
            ovf_b  <= 1'b0;
            key_ok <= key_hit;
        end else if (state == CALC && !finish) begin
            a     <= b;
            b     <= sum;
            ovf_a <= ovf_b;
            ovf_b <= ovf_a | ovf_b | carry;
            cnt   <= cnt - N_W'(1);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ap_return <= '0;
            ap_ovf    <= 1'b0;
        end else if (finish) begin
            ap_return <= key_ok ? a : ~a;
            ap_ovf    <= key_ok & ovf_a;
        end
    end

    assign ap_done  = (state == DONE);
    assign ap_ready = (state == DONE);
    assign ap_idle  = (state == IDLE);

endmodule

// File: tb/tb_fibo_engine.sv
// tb_fibo_engine: directed and randomized checks of fibo_engine (32 and 16 bit)
// against a wide-integer Fibonacci reference model.
module tb_fibo_engine;

    localparam logic [63:0] KEY = 64'hA5A5_0123_4567_89AB;

    typedef struct {
        logic [31:0] r32;
        logic        o32;
        logic [15:0] r16;
        logic        o16;
        int          cyc;
        bit          stable;
        bit          ready_ok;
        bit          tail_ok;
        bit          timeout;
    } job_t;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        ap_start;
    logic [31:0] n_in;
    logic [31:0] mod_in;
    logic [15:0] mod16;
    logic        done32, idle32, ready32, ovf32;
    logic [31:0] ret32;
    logic        done16, idle16, ready16, ovf16;
    logic [15:0] ret16;
`ifdef FIBO_KEY_LOCK_EN
    logic [63:0] working_key;
`endif

    int checks;
    int fails;

    assign mod16 = mod_in[15:0];

    fibo_engine #(
        .KEY_VAL(KEY)
    ) dut (
`ifdef FIBO_KEY_LOCK_EN
        .working_key(working_key),
`endif
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ap_start (ap_start),
        .ap_done  (done32),
        .ap_idle  (idle32),
        .ap_ready (ready32),
        .n        (n_in),
        .mod_m    (mod_in),
        .ap_return(ret32),
        .ap_ovf   (ovf32)
    );

    fibo_engine #(
        .DATA_W (16),
        .KEY_VAL(KEY)
    ) dut16 (
`ifdef FIBO_KEY_LOCK_EN
        .working_key(working_key),
`endif
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ap_start (ap_start),
        .ap_done  (done16),
        .ap_idle  (idle16),
        .ap_ready (ready16),
        .n        (n_in),
        .mod_m    (mod16),
        .ap_return(ret16),
        .ap_ovf   (ovf16)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Reference: exact F(n) in 128 bits, then reduce by the rules.
    function automatic void model(input int nn, input logic [31:0] mm,
                                  input int w, input bit good,
                                  output logic [31:0] r, output logic o);
        logic [127:0] a, b, t, mask, mw;
        a = 0;
        b = 1;
        for (int i = 0; i < nn; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        mask = (128'd1 << w) - 1;
        mw   = {96'd0, mm} & mask;
        if (mw == 0) begin
            r = 32'(a & mask);
            o = (a > mask);
        end else begin
            r = 32'(a % mw);
            o = 1'b0;
        end
        if (!good) begin
            r = 32'(~{96'd0, r} & mask);
            o = 1'b0;
        end
    endfunction

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge ap_clk);
        while (!idle32 && g < 50) begin
            @(negedge ap_clk);
            g++;
        end
    endtask

    task automatic run_job(input int nn, input logic [31:0] mm,
                           input bit poke, input bit good, output job_t j);
        logic [31:0] p32;
        logic [15:0] p16;
        logic        po32, po16;
        bit          got;
        wait_idle();
        n_in   = nn;
        mod_in = mm;
`ifdef FIBO_KEY_LOCK_EN
        working_key = good ? KEY : KEY ^ {32'($urandom), 32'($urandom) | 32'h1};
`else
        if (!good) $display("note: key lock not built, key ignored");
`endif
        p32  = ret32;
        po32 = ovf32;
        p16  = ret16;
        po16 = ovf16;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        n_in     = $urandom;
        mod_in   = $urandom;
        j = '{r32: 0, o32: 0, r16: 0, o16: 0, cyc: 0,
              stable: 1, ready_ok: 0, tail_ok: 0, timeout: 0};
        got = 1'b0;
        while (!got && j.cyc < nn + 10) begin
            @(negedge ap_clk);
            j.cyc++;
            if (poke && j.cyc == 2) ap_start = 1'b1;
            if (poke && j.cyc == 4) ap_start = 1'b0;
            if (done32) begin
                got        = 1'b1;
                j.r32      = ret32;
                j.o32      = ovf32;
                j.r16      = ret16;
                j.o16      = ovf16;
                j.ready_ok = ready32 && done16 && ready16;
            end else if (ret32 !== p32 || ovf32 !== po32 ||
                         ret16 !== p16 || ovf16 !== po16) begin
                j.stable = 1'b0;
            end
        end
        j.timeout = !got;
        if (got) begin
            @(negedge ap_clk);
            j.tail_ok = !done32 && !ready32 && idle32;
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        n_in     = 0;
        mod_in   = 0;
`ifdef FIBO_KEY_LOCK_EN
        working_key = KEY;
`endif
        repeat (3) @(negedge ap_clk);
        checks++;
        if (ret32 !== 32'd0 || ovf32 !== 1'b0) begin
            fails++;
            $display("FAIL reset_out: ret=%0d ovf=%0b want 0 0", ret32, ovf32);
        end
        checks++;
        if (done32 !== 1'b0 || ready32 !== 1'b0 || idle32 !== 1'b1) begin
            fails++;
            $display("FAIL reset_ctl: done=%0b ready=%0b idle=%0b want 0 0 1",
                     done32, ready32, idle32);
        end
        checks++;
        if (ret16 !== 16'd0 || idle16 !== 1'b1) begin
            fails++;
            $display("FAIL reset_16: ret=%0d idle=%0b want 0 1", ret16, idle16);
        end
        ap_rst_n = 1'b1;
    endtask

    task automatic test_basic();
        job_t j;
        run_job(10, 0, 1'b0, 1'b1, j);
        checks++;
        if (j.timeout) begin
            fails++;
            $display("FAIL basic_timeout: no ap_done within %0d cycles", j.cyc);
        end
        checks++;
        if (j.r32 !== 32'd55 || j.o32 !== 1'b0) begin
            fails++;
            $display("FAIL basic_result: got %0d/%0b want 55/0", j.r32, j.o32);
        end
        checks++;
        if (j.cyc !== 12) begin
            fails++;
            $display("FAIL basic_latency: got %0d want 12", j.cyc);
        end
        checks++;
        if (!j.ready_ok || !j.tail_ok || !j.stable) begin
            fails++;
            $display("FAIL basic_handshake: ready=%0b tail=%0b stable=%0b want 1 1 1",
                     j.ready_ok, j.tail_ok, j.stable);
        end
    endtask

    task automatic test_back_to_back();
        wait_idle();
        n_in     = 0;
        mod_in   = 0;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        n_in = 1;
        repeat (2) @(negedge ap_clk);
        checks++;
        if (done32 !== 1'b1 || ret32 !== 32'd0) begin
            fails++;
            $display("FAIL b2b_first: done=%0b ret=%0d want 1 0", done32, ret32);
        end
        @(negedge ap_clk);
        checks++;
        if (idle32 !== 1'b1 || done32 !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle_gap: idle=%0b done=%0b want 1 0", idle32, done32);
        end
        @(negedge ap_clk);
        checks++;
        if (idle32 !== 1'b0) begin
            fails++;
            $display("FAIL b2b_restart: idle=%0b want 0", idle32);
        end
        repeat (2) @(negedge ap_clk);
        ap_start = 1'b0;
        checks++;
        if (done32 !== 1'b1 || ret32 !== 32'd1) begin
            fails++;
            $display("FAIL b2b_second: done=%0b ret=%0d want 1 1", done32, ret32);
        end
    endtask

    task automatic test_width16();
        job_t j;
        run_job(24, 0, 1'b0, 1'b1, j);
        checks++;
        if (j.r16 !== 16'd46368 || j.o16 !== 1'b0) begin
            fails++;
            $display("FAIL w16_n24: got %0d/%0b want 46368/0", j.r16, j.o16);
        end
        run_job(25, 0, 1'b0, 1'b1, j);
        checks++;
        if (j.r16 !== 16'd9489 || j.o16 !== 1'b1) begin
            fails++;
            $display("FAIL w16_n25: got %0d/%0b want 9489/1", j.r16, j.o16);
        end
        checks++;
        if (j.r32 !== 32'd75025 || j.o32 !== 1'b0) begin
            fails++;
            $display("FAIL w32_n25: got %0d/%0b want 75025/0", j.r32, j.o32);
        end
    endtask

    task automatic test_modulus();
        job_t        j;
        logic [31:0] e;
        logic        eo;
        run_job(20, 1000, 1'b0, 1'b1, j);
        checks++;
        if (j.r32 !== 32'd765 || j.r16 !== 16'd765 || j.o32 !== 1'b0) begin
            fails++;
            $display("FAIL mod_1000: got %0d/%0d/%0b want 765/765/0",
                     j.r32, j.r16, j.o32);
        end
        run_job(5, 1, 1'b0, 1'b1, j);
        checks++;
        if (j.r32 !== 32'd0 || j.r16 !== 16'd0) begin
            fails++;
            $display("FAIL mod_1: got %0d/%0d want 0/0", j.r32, j.r16);
        end
        run_job(60, 32'hFFFF_FFFB, 1'b0, 1'b1, j);
        model(60, 32'hFFFF_FFFB, 32, 1'b1, e, eo);
        checks++;
        if (j.r32 !== e || j.o32 !== eo) begin
            fails++;
            $display("FAIL mod_big: got %0h/%0b want %0h/%0b", j.r32, j.o32, e, eo);
        end
    endtask

    task automatic test_start_ignored();
        job_t j;
        run_job(10, 0, 1'b1, 1'b1, j);
        checks++;
        if (j.r32 !== 32'd55 || j.cyc !== 12 || !j.stable) begin
            fails++;
            $display("FAIL start_in_calc: got %0d in %0d cycles want 55 in 12",
                     j.r32, j.cyc);
        end
    endtask

    task automatic test_reset_mid_run();
        job_t j;
        wait_idle();
        n_in     = 30;
        mod_in   = 0;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        repeat (5) @(negedge ap_clk);
        #2;
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if (ret32 !== 32'd0 || ovf32 !== 1'b0 || idle32 !== 1'b1 ||
            done32 !== 1'b0 || ret16 !== 16'd0) begin
            fails++;
            $display("FAIL midrun_reset: ret=%0d ovf=%0b idle=%0b done=%0b",
                     ret32, ovf32, idle32, done32);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        run_job(7, 0, 1'b0, 1'b1, j);
        checks++;
        if (j.r32 !== 32'd13 || j.cyc !== 9) begin
            fails++;
            $display("FAIL after_reset: got %0d in %0d cycles want 13 in 9",
                     j.r32, j.cyc);
        end
    endtask

    task automatic test_random();
        job_t        j;
        int          nn;
        int          sel;
        logic [31:0] mm, e32, e16;
        logic        eo32, eo16;
        bit          good;
        for (int k = 0; k < 24; k++) begin
            nn  = $urandom_range(0, 100);
            sel = $urandom_range(0, 2);
            mm  = (sel == 0) ? 32'd0 :
                  (sel == 1) ? 32'($urandom_range(1, 50)) : 32'($urandom);
`ifdef FIBO_KEY_LOCK_EN
            good = ($urandom_range(0, 1) == 1);
`else
            good = 1'b1;
`endif
            run_job(nn, mm, 1'b0, good, j);
            model(nn, mm, 32, good, e32, eo32);
            model(nn, mm, 16, good, e16, eo16);
            checks++;
            if (j.r32 !== e32 || j.o32 !== eo32 || j.cyc !== nn + 2) begin
                fails++;
                $display("FAIL rand32 n=%0d m=%0d: got %0h/%0b/%0d want %0h/%0b/%0d",
                         nn, mm, j.r32, j.o32, j.cyc, e32, eo32, nn + 2);
            end
            checks++;
            if (j.r16 !== e16[15:0] || j.o16 !== eo16 || !j.stable) begin
                fails++;
                $display("FAIL rand16 n=%0d m=%0d: got %0h/%0b want %0h/%0b",
                         nn, mm[15:0], j.r16, j.o16, e16[15:0], eo16);
            end
        end
    endtask

`ifdef FIBO_KEY_LOCK_EN
    task automatic test_key();
        job_t j;
        run_job(10, 0, 1'b0, 1'b1, j);
        checks++;
        if (j.r32 !== 32'd55) begin
            fails++;
            $display("FAIL key_good: got %0h want 37", j.r32);
        end
        run_job(10, 0, 1'b1, 1'b0, j);
        checks++;
        if (j.r32 !== 32'hFFFF_FFC8 || j.o32 !== 1'b0 || j.cyc !== 12) begin
            fails++;
            $display("FAIL key_bad: got %0h/%0b in %0d want ffffffc8/0 in 12",
                     j.r32, j.o32, j.cyc);
        end
        run_job(50, 0, 1'b0, 1'b0, j);
        checks++;
        if (j.o32 !== 1'b0) begin
            fails++;
            $display("FAIL key_bad_ovf: got %0b want 0", j.o32);
        end
    endtask
`endif

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_width16();
        test_modulus();
        test_start_ignored();
        test_reset_mid_run();
        test_random();
`ifdef FIBO_KEY_LOCK_EN
        test_key();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
